// File: rtl/clut_loader.sv
// CLUT fill engine: tracks resident 16-colour blocks of the current CLUT and
// loads a missing block with an 8-beat VRAM burst into the CLUT cache.
module clut_loader (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_clutSet,
    input  logic [5:0]  i_clutX,
    input  logic [8:0]  i_clutY,
    input  logic        i_fetchReq,
    input  logic [3:0]  i_fetchBlock,
    output logic        o_ready,
    output logic [15:0] o_blockValid,
    output logic        o_memReq,
    output logic [18:0] o_memAddr,
    input  logic        i_memAck,
    input  logic        i_memValid,
    input  logic [31:0] i_memData,
    output logic        o_write,
    output logic [3:0]  o_writeBlockIndex,
    output logic [2:0]  o_writeIdxInBlk,
    output logic [31:0] o_Colors
);

    typedef enum logic [1:0] {IDLE, REQ, DATA, DONE} state_t;

    state_t      state, stateNext;
    logic [5:0]  tagX;
    logic [8:0]  tagY;
    logic [3:0]  block;
    logic [2:0]  beatCnt;
    logic        stale;

    logic        tagChange;
    logic [5:0]  effX;
    logic [8:0]  effY;
    logic [15:0] effValid;
    logic [5:0]  addrX;
    logic        fetchMiss;
    logic        beat;
    logic        lastBeat;

    // A changed tag takes effect in the same cycle, so a fetch arriving with
    // it sees all blocks invalid and addresses the new CLUT position.
    assign tagChange = i_clutSet && ({i_clutX, i_clutY} != {tagX, tagY});
    assign effX      = tagChange ? i_clutX : tagX;
    assign effY      = tagChange ? i_clutY : tagY;
    assign effValid  = tagChange ? 16'd0 : o_blockValid;
    // X wraps modulo 64 so the burst stays on the same VRAM line.
    assign addrX     = effX + {2'b00, i_fetchBlock};
    assign fetchMiss = (state == IDLE) && i_fetchReq && !effValid[i_fetchBlock];
    assign beat      = (state == DATA) && i_memValid;
    assign lastBeat  = beat && (beatCnt == 3'd7);

    // Both are decodes of the state register, so they behave as registered outputs.
    assign o_ready  = (state == IDLE);
    assign o_memReq = (state == REQ);

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) state <= IDLE;
        else       state <= stateNext;
    end

    // Next-state logic for the fill sequence.
    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (fetchMiss) stateNext = REQ;
            REQ:     if (i_memAck)  stateNext = DATA;
            DATA:    if (lastBeat)  stateNext = DONE;
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Tag, residency flags, burst bookkeeping and cache write port.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            tagX              <= '0;
            tagY              <= '0;
            o_blockValid      <= '0;
            block             <= '0;
            beatCnt           <= '0;
            stale             <= 1'b0;
            o_memAddr         <= '0;
            o_write           <= 1'b0;
            o_writeBlockIndex <= '0;
            o_writeIdxInBlk   <= '0;
            o_Colors          <= '0;
        end else begin
            o_write <= 1'b0;

            if (tagChange) begin
                tagX <= i_clutX;
                tagY <= i_clutY;
            end

            // A block fetched for an old tag must never be marked resident;
            // DONE in the same cycle as a tag change also loses its bit.
            if (tagChange)
                o_blockValid <= '0;
            else if (state == DONE && !stale)
                o_blockValid[block] <= 1'b1;

            if (tagChange && state != IDLE)
                stale <= 1'b1;

            if (fetchMiss) begin
                block     <= i_fetchBlock;
                beatCnt   <= '0;
                stale     <= 1'b0;
                o_memAddr <= {effY, addrX, 3'b000};
            end

            if (beat) begin
                o_write           <= 1'b1;
                o_writeBlockIndex <= block;
                o_writeIdxInBlk   <= beatCnt;
                o_Colors          <= i_memData;
                beatCnt           <= beatCnt + 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_clut_loader.sv
// Bench for clut_loader: table of fetch vectors plus hand-written corner
// sequences; cache writes are checked against a scoreboard queue.
module tb_clut_loader;

    logic        i_clk = 1'b0;
    logic        i_rst, i_clutSet, i_fetchReq, i_memAck, i_memValid;
    logic [5:0]  i_clutX;
    logic [8:0]  i_clutY;
    logic [3:0]  i_fetchBlock;
    logic [31:0] i_memData;
    logic        o_ready, o_memReq, o_write;
    logic [15:0] o_blockValid;
    logic [18:0] o_memAddr;
    logic [3:0]  o_writeBlockIndex;
    logic [2:0]  o_writeIdxInBlk;
    logic [31:0] o_Colors;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0]  blk;
        logic [2:0]  idx;
        logic [31:0] data;
    } wr_t;
    wr_t sb[$];

    typedef struct {
        logic [5:0]  x;
        logic [8:0]  y;
        logic [3:0]  blk;
        int          gap;
        logic [18:0] addr;
        logic [15:0] vBefore;
        logic [15:0] vAfter;
    } vec_t;
    vec_t vecs[4];

    clut_loader dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_clutSet(i_clutSet), .i_clutX(i_clutX),
        .i_clutY(i_clutY), .i_fetchReq(i_fetchReq), .i_fetchBlock(i_fetchBlock),
        .o_ready(o_ready), .o_blockValid(o_blockValid), .o_memReq(o_memReq),
        .o_memAddr(o_memAddr), .i_memAck(i_memAck), .i_memValid(i_memValid),
        .i_memData(i_memData), .o_write(o_write), .o_writeBlockIndex(o_writeBlockIndex),
        .o_writeIdxInBlk(o_writeIdxInBlk), .o_Colors(o_Colors)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Scoreboard: every write strobe must match the oldest expected beat.
    always @(negedge i_clk) begin
        if (o_write) begin
            if (sb.size() == 0) begin
                check("unexpected_write", 32'd1, 32'd0);
            end else begin
                wr_t e;
                e = sb.pop_front();
                check("wr_block", {28'd0, o_writeBlockIndex}, {28'd0, e.blk});
                check("wr_idx", {29'd0, o_writeIdxInBlk}, {29'd0, e.idx});
                check("wr_data", o_Colors, e.data);
            end
        end
    end

    task automatic cyc;
        @(posedge i_clk);
        #1;
    endtask

    task automatic setClut(input logic [5:0] x, input logic [8:0] y);
        i_clutSet = 1'b1; i_clutX = x; i_clutY = y;
        cyc();
        i_clutSet = 1'b0;
    endtask

    // Miss fetch: o_memReq must be up the cycle after acceptance.
    task automatic fetchMiss(input logic [3:0] blk, input logic [18:0] addr);
        i_fetchReq = 1'b1; i_fetchBlock = blk;
        cyc();
        i_fetchReq = 1'b0;
        check("memReq_up", {31'd0, o_memReq}, 32'd1);
        check("ready_low", {31'd0, o_ready}, 32'd0);
        check("memAddr", {13'd0, o_memAddr}, {13'd0, addr});
    endtask

    // Hold the request a while (with a stray beat that must be ignored), then ack.
    task automatic ack;
        i_memValid = 1'b1; i_memData = 32'hDEAD_BEEF;
        cyc();
        i_memValid = 1'b0;
        cyc();
        check("memReq_held", {31'd0, o_memReq}, 32'd1);
        i_memAck = 1'b1;
        cyc();
        i_memAck = 1'b0;
        check("memReq_drop", {31'd0, o_memReq}, 32'd0);
    endtask

    task automatic beats(input logic [3:0] blk, input int first, input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            i_memValid = 1'b1;
            i_memData  = $urandom;
            sb.push_back('{blk, 3'(first + i), i_memData});
            cyc();
            i_memValid = 1'b0;
            if (i != n - 1) repeat (gap) cyc();
        end
    endtask

    // After the final beat: one cycle in DONE, then idle with the flag updated.
    task automatic finish(input logic [15:0] vExp);
        check("ready_done", {31'd0, o_ready}, 32'd0);
        cyc();
        check("ready_back", {31'd0, o_ready}, 32'd1);
        check("blockValid", {16'd0, o_blockValid}, {16'd0, vExp});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{6'd2,  9'd480, 4'd0,  0, 19'h3C010, 16'h0000, 16'h0001};
        vecs[1] = '{6'd63, 9'd5,   4'd3,  0, 19'h00A10, 16'h0000, 16'h0008};
        vecs[2] = '{6'd63, 9'd5,   4'd5,  3, 19'h00A20, 16'h0008, 16'h0028};
        vecs[3] = '{6'd10, 9'd0,   4'd15, 1, 19'h000C8, 16'h0000, 16'h8000};

        i_rst = 1'b1; i_clutSet = 1'b0; i_clutX = '0; i_clutY = '0;
        i_fetchReq = 1'b0; i_fetchBlock = '0; i_memAck = 1'b0;
        i_memValid = 1'b0; i_memData = '0;
        repeat (3) cyc();
        i_rst = 1'b0;
        check("rst_ready", {31'd0, o_ready}, 32'd1);
        check("rst_valid", {16'd0, o_blockValid}, 32'd0);
        check("rst_memReq", {31'd0, o_memReq}, 32'd0);
        check("rst_memAddr", {13'd0, o_memAddr}, 32'd0);
        check("rst_write", {31'd0, o_write}, 32'd0);
        check("rst_wblk", {28'd0, o_writeBlockIndex}, 32'd0);
        check("rst_widx", {29'd0, o_writeIdxInBlk}, 32'd0);
        check("rst_colors", o_Colors, 32'd0);

        // Table: address formation, wrap, gapped beats, same-tag no-op.
        for (int v = 0; v < 4; v++) begin
            setClut(vecs[v].x, vecs[v].y);
            check("valid_after_set", {16'd0, o_blockValid}, {16'd0, vecs[v].vBefore});
            fetchMiss(vecs[v].blk, vecs[v].addr);
            ack();
            beats(vecs[v].blk, 0, 8, vecs[v].gap);
            finish(vecs[v].vAfter);
        end

        // Fetch of a resident block: nothing happens.
        i_fetchReq = 1'b1; i_fetchBlock = 4'd15;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("hit_memReq", {31'd0, o_memReq}, 32'd0);
            check("hit_ready", {31'd0, o_ready}, 32'd1);
        end
        i_fetchReq = 1'b0;
        check("hit_valid", {16'd0, o_blockValid}, 32'h8000);

        // Tag change mid-burst: burst completes but block stays invalid.
        setClut(6'd20, 9'd7);
        fetchMiss(4'd2, 19'h00EB0);
        ack();
        beats(4'd2, 0, 5, 0);
        setClut(6'd21, 9'd7);
        beats(4'd2, 5, 3, 0);
        finish(16'h0000);
        fetchMiss(4'd2, 19'h00EB8);
        ack();
        beats(4'd2, 0, 8, 0);
        finish(16'h0004);

        // Tag change together with a fetch of a previously resident block.
        i_clutSet = 1'b1; i_clutX = 6'd0; i_clutY = 9'd1;
        i_fetchReq = 1'b1; i_fetchBlock = 4'd2;
        cyc();
        i_clutSet = 1'b0; i_fetchReq = 1'b0;
        check("simul_valid", {16'd0, o_blockValid}, 32'd0);
        check("simul_memReq", {31'd0, o_memReq}, 32'd1);
        check("simul_addr", {13'd0, o_memAddr}, 32'h00210);
        ack();
        beats(4'd2, 0, 8, 0);
        finish(16'h0004);

        // Reset during DATA, then stray beats must be ignored.
        fetchMiss(4'd9, 19'h00248);
        ack();
        beats(4'd9, 0, 3, 0);
        i_rst = 1'b1;
        cyc();
        i_rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            i_memValid = 1'b1; i_memData = $urandom;
            cyc();
        end
        i_memValid = 1'b0;
        cyc();
        check("rstmid_ready", {31'd0, o_ready}, 32'd1);
        check("rstmid_valid", {16'd0, o_blockValid}, 32'd0);
        check("rstmid_memReq", {31'd0, o_memReq}, 32'd0);

        cyc();
        check("sb_empty", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/clut_loader.md
# clut_loader

Fill engine for the GPU texture-palette (CLUT) cache. It tracks which 16-colour blocks of the current CLUT are resident and, on a fetch request for a missing block, issues an 8-beat VRAM burst read. Each returned 32-bit word (two 16-bit colours) is forwarded to the CLUT cache write port. It sits between the texture sampler, which asks for blocks on a miss, and the VRAM memory arbiter.

## Interface
Parameters: none.

Ports:
- i_clk  in  1  clock; all logic on its rising edge.
- i_rst  in  1  reset, synchronous, active-high.
- i_clutSet  in  1  pulse: new CLUT position from the primitive setup.
- i_clutX  in  6  CLUT X in 16-pixel units.
- i_clutY  in  9  CLUT Y (VRAM line).
- i_fetchReq  in  1  request to load one block; sampled only when o_ready=1.
- i_fetchBlock  in  4  block index (palette entries [16*b+15 : 16*b]).
- o_ready  out  1  loader idle; accepts i_fetchReq.
- o_blockValid  out  16  per-block resident flags for the current CLUT.
- o_memReq  out  1  burst request; held until acknowledged.
- o_memAddr  out  19  32-bit word address of the burst start.
- i_memAck  in  1  arbiter accepted the request (1-cycle pulse).
- i_memValid  in  1  read-data beat valid.
- i_memData  in  32  read data; [15:0] is the even colour, [31:16] the odd colour.
- o_write  out  1  cache write strobe.
- o_writeBlockIndex  out  4  cache block being filled.
- o_writeIdxInBlk  out  3  word index within the block (0..7).
- o_Colors  out  32  cache write data (i_memData passed through unchanged).

## Operation
- State machine IDLE / REQ / DATA / DONE. o_ready = (state==IDLE).
- Tag: registered {clutX, clutY}. An i_clutSet pulse with a value different from the tag loads the new tag and clears o_blockValid to 0, in any state. An i_clutSet pulse equal to the tag is a no-op.
- IDLE with i_fetchReq:
  - If o_blockValid[i_fetchBlock]=1: no action, stay in IDLE.
  - Otherwise latch the block, clear the beat counter and the stale flag, and go to REQ.
- REQ:
  - o_memReq=1.
  - o_memAddr = {tagY, (tagX + block) mod 64, 3'b000}, so pixel X wraps within the same VRAM line.
  - On i_memAck, go to DATA.
- DATA:
  - Each i_memValid beat produces one registered write: o_write=1, o_writeBlockIndex=block, o_writeIdxInBlk=counter, o_Colors=i_memData. The counter then increments.
  - Beats may have any number of idle cycles between them.
  - After beat 7 go to DONE.
- DONE: set o_blockValid[block]=1 unless the stale flag is set, then return to IDLE.
- Stale: a tag change during REQ/DATA/DONE sets the stale flag. The in-flight burst still completes and still writes the cache, so the bus stays consistent, but the block is not marked valid.
- i_memValid outside DATA and i_memAck outside REQ are ignored.
- i_fetchReq while o_ready=0 is ignored; the requester must hold it.
- Simultaneous i_clutSet (changed tag) and accepted i_fetchReq in IDLE: the valid bits clear first. The fetch is then evaluated as a miss and addresses the new tag.
- Reset: state IDLE, o_ready=1, o_blockValid=0, tag=0, o_memReq=0, o_memAddr=0, o_write=0, o_writeBlockIndex=0, o_writeIdxInBlk=0, o_Colors=0, counter 0, stale 0. A reset during a burst abandons it; later beats are ignored.

## Timing
- All outputs are registered.
- Accepted miss at cycle N: o_memReq=1 from N+1. i_memAck at cycle A: o_memReq=0 from A+1, and a beat is accepted from A+1.
- Beat at cycle B: o_write=1 at B+1 for exactly 1 cycle.
- Last beat at cycle L: o_write(idx 7) at L+1, o_blockValid bit set and o_ready=1 at L+2. This lets the cache commit before any reader sees the block as valid.
- Minimum miss-to-valid with ack at N+1 and back-to-back beats from N+2: valid at N+11.
- Valid-block fetch: no outputs change and o_ready stays 1.

## Test plan
- Reset, then clutSet(X=2,Y=480) and fetch block 0 -> o_memAddr=0x3C010, 8 writes idx 0..7 block 0 with data passed through, o_blockValid=0x0001 two cycles after the last beat.
- Wrap: clutSet(X=63,Y=5), fetch block 3 -> o_memAddr={9'd5,6'd2,3'b000}=0x00A10.
- Gapped beats (3 idle cycles between each) -> exactly 8 writes, idx contiguous 0..7, none on idle cycles.
- Repeat fetch of a resident block -> no o_memReq and o_ready stays 1. clutSet with the same tag -> o_blockValid unchanged.
- clutSet with a new tag after beat 4 -> beats 5..7 still written, o_blockValid=0 at completion. A subsequent fetch uses the new address.
- i_rst asserted mid-DATA, then stray i_memValid beats -> no o_write, o_blockValid=0, o_ready=1.
